// File: rtl/compuertas_pkg.sv
// Shared definitions for the gate-unit sequencer: select encodings, FSM states
// and the reference truth table for each operation.
package compuertas_pkg;

    localparam logic [2:0] SEL_OFF  = 3'b000;
    localparam logic [2:0] SEL_AND  = 3'b001;
    localparam logic [2:0] SEL_OR   = 3'b010;
    localparam logic [2:0] SEL_XOR  = 3'b011;
    localparam logic [2:0] SEL_NAND = 3'b100;
    localparam logic [2:0] SEL_NOR  = 3'b101;
    localparam logic [2:0] SEL_XNOR = 3'b110;

    typedef enum logic [2:0] {
        REPOSO,
        ACTIVAR,
        APLICAR,
        ESPERA,
        REPORTE,
        FIN
    } estado_t;

    // Bit i is the gate output for {ent1,ent2,ent3} = i.
    function automatic logic [7:0] tabla_esperada(input logic [2:0] sel);
        logic [7:0] t;
        case (sel)
            SEL_AND:  t = 8'h80;
            SEL_OR:   t = 8'hFE;
            SEL_XOR:  t = 8'h96;
            SEL_NAND: t = 8'h7F;
            SEL_NOR:  t = 8'h01;
            SEL_XNOR: t = 8'h69;
            default:  t = 8'h00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/secuenciador_compuertas_if.sv
// Connection to the three-input gate unit: the sequencer drives the data
// inputs, enable and select, and reads back the single gate output.
interface secuenciador_compuertas_if;
    logic       ent1;
    logic       ent2;
    logic       ent3;
    logic       act;
    logic [2:0] sel;
    logic       sal;

    modport master (output ent1, ent2, ent3, act, sel, input sal);
    modport slave  (input ent1, ent2, ent3, act, sel, output sal);
endinterface

// File: rtl/contador_espera.sv
// Settle counter: loads 1 when a combination is applied and counts up to
// SETTLE; listo marks the cycle in which the gate output may be sampled.
module contador_espera #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carga,
    input  logic avanza,
    output logic listo
);
    localparam logic [3:0] LIMITE = 4'(SETTLE);

    logic [3:0] cuenta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= 4'd0;
        end else if (carga) begin
            cuenta <= 4'd1;
        end else if (avanza) begin
            cuenta <= cuenta + 4'd1;
        end
    end

    assign listo = (cuenta == LIMITE);

endmodule

// File: rtl/secuenciador_compuertas.sv
// Sweeps the gate unit through all six operations and eight input combinations,
// captures each truth table and flags tables that differ from the reference.
module secuenciador_compuertas
    import compuertas_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inicio,
    input  logic                         abortar,
    secuenciador_compuertas_if.master    compuerta,
    output logic [7:0]                   tabla,
    output logic [2:0]                   tabla_sel,
    output logic                         tabla_valida,
    output logic                         discrepa,
    output logic [2:0]                   errores,
    output logic                         ocupado,
    output logic                         fin
);
    estado_t    estado;
    logic [2:0] combo;
    logic [2:0] ent_reg;
    logic       act_reg;
    logic [2:0] sel_reg;
    logic       listo;
    logic       carga;
    logic       avanza;
    logic       difiere;

    assign compuerta.ent1 = ent_reg[2];
    assign compuerta.ent2 = ent_reg[1];
    assign compuerta.ent3 = ent_reg[0];
    assign compuerta.act  = act_reg;
    assign compuerta.sel  = sel_reg;

    assign ocupado = (estado != REPOSO);
    assign difiere = (tabla != tabla_esperada(sel_reg));
    assign carga   = (estado == APLICAR);
    assign avanza  = (estado == ESPERA) && !listo;

    contador_espera #(.SETTLE(SETTLE)) u_espera (
        .clk    (clk),
        .rst_n  (rst_n),
        .carga  (carga),
        .avanza (avanza),
        .listo  (listo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= REPOSO;
            combo        <= 3'd0;
            ent_reg      <= 3'd0;
            act_reg      <= 1'b0;
            sel_reg      <= SEL_OFF;
            tabla        <= 8'h00;
            tabla_sel    <= 3'd0;
            tabla_valida <= 1'b0;
            discrepa     <= 1'b0;
            errores      <= 3'd0;
            fin          <= 1'b0;
        end else begin
            tabla_valida <= 1'b0;
            fin          <= 1'b0;
            // Abort wins over everything, including inicio in the same cycle.
            if (abortar && estado != REPOSO) begin
                estado  <= REPOSO;
                act_reg <= 1'b0;
                sel_reg <= SEL_OFF;
                ent_reg <= 3'd0;
            end else begin
                case (estado)
                    REPOSO: begin
                        if (inicio && !abortar) begin
                            errores <= 3'd0;
                            estado  <= ACTIVAR;
                        end
                    end
                    ACTIVAR: begin
                        act_reg <= 1'b1;
                        sel_reg <= SEL_AND;
                        combo   <= 3'd0;
                        estado  <= APLICAR;
                    end
                    APLICAR: begin
                        ent_reg <= combo;
                        // Table of the previous operation stays visible through its report cycle.
                        if (combo == 3'd0) begin
                            tabla <= 8'h00;
                        end
                        estado <= ESPERA;
                    end
                    ESPERA: begin
                        if (listo) begin
                            tabla[combo] <= compuerta.sal;
                            if (combo == 3'd7) begin
                                estado <= REPORTE;
                            end else begin
                                combo  <= combo + 3'd1;
                                estado <= APLICAR;
                            end
                        end
                    end
                    REPORTE: begin
                        tabla_valida <= 1'b1;
                        tabla_sel    <= sel_reg;
                        discrepa     <= difiere;
                        if (difiere && errores != 3'd7) begin
                            errores <= errores + 3'd1;
                        end
                        if (sel_reg == SEL_XNOR) begin
                            estado <= FIN;
                        end else begin
                            sel_reg <= sel_reg + 3'd1;
                            combo   <= 3'd0;
                            estado  <= APLICAR;
                        end
                    end
                    FIN: begin
                        fin     <= 1'b1;
                        act_reg <= 1'b0;
                        sel_reg <= SEL_OFF;
                        ent_reg <= 3'd0;
                        estado  <= REPOSO;
                    end
                    default: estado <= REPOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_compuertas.sv
// Directed bench for the gate sequencer: clean, faulty and delayed gate models,
// abort, ignored starts and asynchronous reset in the middle of a sweep.
module tb_secuenciador_compuertas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic inicio1, abortar1, inicio3, abortar3;

    logic [7:0] tabla1, tabla3;
    logic [2:0] tabla_sel1, tabla_sel3, errores1, errores3;
    logic       tabla_valida1, tabla_valida3, discrepa1, discrepa3;
    logic       ocupado1, ocupado3, fin1, fin3;

    secuenciador_compuertas_if bus1();
    secuenciador_compuertas_if bus3();

    secuenciador_compuertas #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio1), .abortar(abortar1),
        .compuerta(bus1), .tabla(tabla1), .tabla_sel(tabla_sel1),
        .tabla_valida(tabla_valida1), .discrepa(discrepa1), .errores(errores1),
        .ocupado(ocupado1), .fin(fin1)
    );

    secuenciador_compuertas #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio3), .abortar(abortar3),
        .compuerta(bus3), .tabla(tabla3), .tabla_sel(tabla_sel3),
        .tabla_valida(tabla_valida3), .discrepa(discrepa3), .errores(errores3),
        .ocupado(ocupado3), .fin(fin3)
    );

    // Gate model; modo 0 = correct, 1 = XOR built as OR, 2 = output delayed 2 cycles.
    int modo1, modo3;

    function automatic logic puerta(input logic a, input logic [2:0] s,
                                    input logic [2:0] e, input int modo);
        logic r;
        r = 1'b0;
        if (a) begin
            case (s)
                3'd1: r = &e;
                3'd2: r = |e;
                3'd3: r = (modo == 1) ? |e : ^e;
                3'd4: r = ~&e;
                3'd5: r = ~|e;
                3'd6: r = ~^e;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    logic ideal1, ideal3, r1a, r1b, r3a, r3b;
    assign ideal1 = puerta(bus1.act, bus1.sel, {bus1.ent1, bus1.ent2, bus1.ent3}, modo1);
    assign ideal3 = puerta(bus3.act, bus3.sel, {bus3.ent1, bus3.ent2, bus3.ent3}, modo3);
    always @(posedge clk) begin
        r1a <= ideal1;
        r1b <= r1a;
        r3a <= ideal3;
        r3b <= r3a;
    end
    assign bus1.sal = (modo1 == 2) ? r1b : ideal1;
    assign bus3.sal = (modo3 == 2) ? r3b : ideal3;

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    logic [11:0] tv_q1[$];
    logic [11:0] tv_q3[$];
    int          fin_q1[$];
    int          fin_q3[$];

    always @(negedge clk) begin
        if (tabla_valida1) begin
            tv_q1.push_back({tabla_sel1, tabla1, discrepa1});
            $display("[%0d] dut1 tabla sel=%0d tabla=%02h discrepa=%0b errores=%0d",
                     ciclo, tabla_sel1, tabla1, discrepa1, errores1);
        end
        if (tabla_valida3) begin
            tv_q3.push_back({tabla_sel3, tabla3, discrepa3});
            $display("[%0d] dut3 tabla sel=%0d tabla=%02h discrepa=%0b errores=%0d",
                     ciclo, tabla_sel3, tabla3, discrepa3, errores3);
        end
        if (fin1) begin
            fin_q1.push_back(ciclo);
            $display("[%0d] dut1 fin errores=%0d", ciclo, errores1);
        end
        if (fin3) begin
            fin_q3.push_back(ciclo);
            $display("[%0d] dut3 fin errores=%0d", ciclo, errores3);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic pulsar_inicio(input int d, output int t0);
        @(negedge clk);
        if (d == 1) inicio1 = 1'b1; else inicio3 = 1'b1;
        @(negedge clk);
        inicio1 = 1'b0;
        inicio3 = 1'b0;
        t0 = ciclo;
    endtask

    task automatic comparar_tablas(input string tag, input int d, input logic [11:0] esp[6]);
        int n;
        n = (d == 1) ? tv_q1.size() : tv_q3.size();
        chequear({tag, "_cuenta"}, n, 6);
        for (int i = 0; i < 6 && i < n; i++) begin
            chequear($sformatf("%s_op%0d", tag, i + 1),
                     (d == 1) ? tv_q1[i] : tv_q3[i], esp[i]);
        end
    endtask

    logic [11:0] esp_limpio[6] = '{{3'd1, 8'h80, 1'b0}, {3'd2, 8'hFE, 1'b0}, {3'd3, 8'h96, 1'b0},
                                   {3'd4, 8'h7F, 1'b0}, {3'd5, 8'h01, 1'b0}, {3'd6, 8'h69, 1'b0}};
    logic [11:0] esp_xor_or[6] = '{{3'd1, 8'h80, 1'b0}, {3'd2, 8'hFE, 1'b0}, {3'd3, 8'hFE, 1'b1},
                                   {3'd4, 8'h7F, 1'b0}, {3'd5, 8'h01, 1'b0}, {3'd6, 8'h69, 1'b0}};
    // SETTLE=1 against a 2-cycle gate: each bit sees the previous combination's result.
    logic [11:0] esp_lento[6]  = '{{3'd1, 8'h00, 1'b1}, {3'd2, 8'hFD, 1'b1}, {3'd3, 8'h2D, 1'b1},
                                   {3'd4, 8'hFF, 1'b1}, {3'd5, 8'h02, 1'b1}, {3'd6, 8'hD2, 1'b1}};

    task automatic limpiar_colas();
        tv_q1.delete();
        tv_q3.delete();
        fin_q1.delete();
        fin_q3.delete();
    endtask

    initial begin
        int t0;
        rst_n    = 1'b0;
        inicio1  = 1'b0;
        abortar1 = 1'b0;
        inicio3  = 1'b0;
        abortar3 = 1'b0;
        modo1    = 0;
        modo3    = 0;
        repeat (3) @(negedge clk);

        chequear("reset_bus", {bus1.act, bus1.sel, bus1.ent1, bus1.ent2, bus1.ent3}, 0);
        chequear("reset_tabla", {tabla_sel1, tabla1}, 0);
        chequear("reset_flags", {ocupado1, fin1, tabla_valida1, discrepa1, errores1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean sweep, with a stray inicio while busy.
        limpiar_colas();
        pulsar_inicio(1, t0);
        chequear("limpio_ocupado", ocupado1, 1);
        @(negedge clk);
        chequear("limpio_act_sel", {bus1.act, bus1.sel}, {1'b1, 3'd1});
        repeat (29) @(negedge clk);
        inicio1 = 1'b1;
        @(negedge clk);
        inicio1 = 1'b0;
        repeat (85) @(negedge clk);
        comparar_tablas("limpio", 1, esp_limpio);
        chequear("limpio_fin_n", fin_q1.size(), 1);
        if (fin_q1.size() > 0) chequear("limpio_fin_t", fin_q1[0] - t0, 104);
        chequear("limpio_errores", errores1, 0);
        chequear("limpio_reposo", {ocupado1, bus1.act, bus1.sel}, 0);

        // Faulty gate: XOR behaves as OR.
        limpiar_colas();
        modo1 = 1;
        pulsar_inicio(1, t0);
        repeat (110) @(negedge clk);
        comparar_tablas("xor_or", 1, esp_xor_or);
        chequear("xor_or_errores", errores1, 1);

        // Slow gate with SETTLE=3.
        limpiar_colas();
        modo3 = 2;
        pulsar_inicio(3, t0);
        repeat (210) @(negedge clk);
        comparar_tablas("lento_s3", 3, esp_limpio);
        chequear("lento_s3_fin_n", fin_q3.size(), 1);
        if (fin_q3.size() > 0) chequear("lento_s3_fin_t", fin_q3[0] - t0, 200);
        chequear("lento_s3_errores", errores3, 0);

        // Same slow gate with SETTLE=1.
        limpiar_colas();
        modo1 = 2;
        pulsar_inicio(1, t0);
        repeat (110) @(negedge clk);
        comparar_tablas("lento_s1", 1, esp_lento);
        chequear("lento_s1_errores", errores1, 6);

        // Abort 40 cycles after start.
        limpiar_colas();
        modo1 = 0;
        pulsar_inicio(1, t0);
        repeat (39) @(negedge clk);
        abortar1 = 1'b1;
        @(negedge clk);
        abortar1 = 1'b0;
        chequear("abort_estado", {ocupado1, bus1.act, bus1.sel, bus1.ent1, bus1.ent2, bus1.ent3}, 0);
        repeat (100) @(negedge clk);
        chequear("abort_pulsos", tv_q1.size(), 2);
        chequear("abort_sin_fin", fin_q1.size(), 0);
        chequear("abort_errores", errores1, 0);

        // inicio and abortar together while idle.
        limpiar_colas();
        inicio1  = 1'b1;
        abortar1 = 1'b1;
        @(negedge clk);
        inicio1  = 1'b0;
        abortar1 = 1'b0;
        chequear("simul_reposo", {ocupado1, bus1.act}, 0);
        repeat (25) @(negedge clk);
        chequear("simul_pulsos", tv_q1.size(), 0);

        // Full clean sweep after the abort.
        limpiar_colas();
        pulsar_inicio(1, t0);
        repeat (110) @(negedge clk);
        comparar_tablas("tras_abort", 1, esp_limpio);
        chequear("tras_abort_fin_n", fin_q1.size(), 1);
        if (fin_q1.size() > 0) chequear("tras_abort_fin_t", fin_q1[0] - t0, 104);
        chequear("tras_abort_errores", errores1, 0);

        // Asynchronous reset in the middle of a faulty sweep.
        limpiar_colas();
        modo1 = 1;
        pulsar_inicio(1, t0);
        repeat (60) @(negedge clk);
        chequear("pre_reset_errores", errores1, 1);
        #2 rst_n = 1'b0;
        #1;
        chequear("rst_bus", {bus1.act, bus1.sel, bus1.ent1, bus1.ent2, bus1.ent3}, 0);
        chequear("rst_tabla", {tabla_sel1, tabla1}, 0);
        chequear("rst_flags", {ocupado1, fin1, tabla_valida1, discrepa1, errores1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chequear("rst_pulsos", tv_q1.size(), 3);
        chequear("rst_sin_fin", fin_q1.size(), 0);
        chequear("rst_reposo", ocupado1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_compuertas.md
# secuenciador_compuertas

Sequencer and result-capture stage wrapped around the three-input logic-gate unit (`ent1/ent2/ent3`, `act`, `sel[2:0]`, `sal`).
- On a start pulse it enables the unit and steps `sel` through all six operations.
- For each operation it applies all eight input combinations, samples `sal` after a settle delay and assembles an 8-bit truth table.
- It reports each table with a one-cycle valid pulse and checks it against the expected table.

It drives the gate unit's inputs (upstream) and consumes its output (downstream), replacing the manual sweep done in simulation.

## Interface
- `SETTLE`, 1: clock cycles between driving a combination and sampling `sal`; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inicio`  in  1  start pulse; honoured only in REPOSO.
- `abortar`  in  1  synchronous abort; from any busy state returns to REPOSO next edge.
- `sal`  in  1  gate unit output.
- `ent1`, `ent2`, `ent3`  out  1 each  gate unit data inputs (registered).
- `act`  out  1  gate unit enable (registered).
- `sel`  out  3  gate unit operation select (registered): 000 OFF, 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR.
- `tabla`  out  8  captured truth table; bit i = `sal` for {ent1,ent2,ent3}=i.
- `tabla_sel`  out  3  operation that `tabla` belongs to.
- `tabla_valida`  out  1  one-cycle pulse: `tabla`/`tabla_sel`/`discrepa` are valid.
- `discrepa`  out  1  `tabla` differs from the expected table; qualified by `tabla_valida`.
- `errores`  out  3  count of mismatching operations in the current sweep; saturates at 7.
- `ocupado`  out  1  high in every state except REPOSO.
- `fin`  out  1  one-cycle pulse when a full sweep completes (not asserted on abort).

## Operation
- **Reset:** all outputs 0; `sel`=000, `act`=0, state REPOSO, internal `combo`=0, settle counter 0.
- **REPOSO:**
  - On `inicio`=1 → ACTIVAR.
  - `errores` clears on this transition; it holds its value while idle.
- **ACTIVAR (1 cycle):** `act`←1, `sel`←001, `combo`←0 → APLICAR.
- **APLICAR:**
  - {ent1,ent2,ent3}←`combo` (ent1 = MSB); counter←1 → ESPERA.
- **ESPERA:**
  - If counter==SETTLE: `tabla[combo]`←`sal` at this edge.
  - If `combo`==7, go to REPORTE; otherwise `combo`←`combo`+1 and go to APLICAR.
  - If counter<SETTLE: counter+1.
- **REPORTE (1 cycle):**
  - `tabla_valida`=1, `tabla_sel`=`sel`, `discrepa`=(`tabla`≠ESPERADA(`sel`)).
  - `errores` increments on mismatch, saturating at 7.
  - Then: if `sel`==110 → FIN; else `sel`←`sel`+1, `combo`←0 → APLICAR.
  - `tabla` is cleared at the start of each operation.
- **FIN (1 cycle):** `fin`=1, `act`←0, `sel`←000, ent*←0 → REPOSO.
- **Expected tables**, indexed by {ent1,ent2,ent3}:
  - AND 0x80, OR 0xFE, XOR (odd parity) 0x96.
  - NAND 0x7F, NOR 0x01, XNOR 0x69.
  - `sel` 000/111 has no expected table; neither value is ever reported.
- **Abort:**
  - `abortar`=1 in any busy state → REPOSO next edge, with `act`=0, `sel`=000, ent*=0.
  - No `tabla_valida` or `fin` pulse; `errores` keeps its partial value.
  - `abortar` in REPOSO is ignored; `abortar` has priority over `inicio` in the same cycle.
- **Restart:** `inicio` while `ocupado`=1 is ignored, with no restart.
- **Asynchronous reset mid-sweep:** immediate return to reset values; no pulses.

## Timing
- `inicio` sampled at edge 0 → `ocupado`=1 from edge 0.
- Edge 1 (ACTIVAR): `act`=1, `sel`=001.
- Each combination occupies SETTLE+1 cycles (APLICAR + SETTLE × ESPERA).
- Per operation: 8·(SETTLE+1) + 1 cycles.
- Full sweep, `inicio` to `fin` pulse: 2 + 6·(8·(SETTLE+1)+1) cycles, i.e. 104 cycles for SETTLE=1.
- `ocupado` falls on the edge after FIN.
- `sal` is assumed stable within SETTLE cycles of ent* changing; the gate unit is combinational, so SETTLE=1 suffices.

## Structure
- **Package `compuertas_pkg`:**
  - sel encoding constants (`SEL_OFF`, `SEL_AND` … `SEL_XNOR`).
  - FSM state enum.
  - Function `tabla_esperada(sel) → [7:0]`.
- **Sub-module:** one natural sub-module, `contador_espera`, the settle counter with load/done. Everything else is a single FSM plus registers.

## Test plan
- **Clean sweep:** behavioural correct gate model, SETTLE=1, `inicio` pulse.
  - → Six `tabla_valida` pulses with (`tabla_sel`,`tabla`) = (1,0x80), (2,0xFE), (3,0x96), (4,0x7F), (5,0x01), (6,0x69).
  - → `discrepa`=0 every time, `errores`=0, `fin` 104 cycles after `inicio`.
- **Faulty gate:** model with XOR implemented as OR.
  - → `tabla_sel`=3 reports `tabla`=0xFE with `discrepa`=1; final `errores`=1.
  - All other operations match.
- **Settle delay:** SETTLE=3, gate model delays `sal` by 2 cycles.
  - → All tables correct; `fin` at 2+6·33=200 cycles.
  - Repeat with SETTLE=1 → mismatches flagged.
- **Abort:** `abortar` asserted 40 cycles after `inicio`.
  - → REPOSO next edge; `act`=0, `sel`=000; no `fin`.
  - Only 2 `tabla_valida` pulses (SETTLE=1).
  - A new `inicio` then runs a full clean sweep and `errores` restarts from 0.
- **Reset and ignored start:**
  - `rst_n` low mid-sweep → all outputs 0 immediately.
  - `inicio` pulses while `ocupado` → no effect on pulse count or timing.
  - Simultaneous `inicio`+`abortar` in REPOSO → stays in REPOSO.
